// File: rtl/apb_bridge_pkg.sv
// Shared types and default widths for the AHB2APB bridge.
package apb_bridge_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          DATA_W_DEF   = 32;
  localparam int          NSEL_DEF     = 4;
  localparam logic [31:0] SEL_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] SEL_SIZE_DEF = 32'h0400_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Request as issued by the AHB-side front end (default widths).
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Address decoder: maps an address onto a one-hot APB slave select.
module apb_addr_decode #(
  parameter int                ADDR_W   = 32,
  parameter int                NSEL     = 4,
  parameter logic [ADDR_W-1:0] SEL_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SEL_SIZE = 32'h0400_0000
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [NSEL-1:0]   sel
);

  // Compare in 64 bits so the window limit cannot wrap around ADDR_W.
  localparam logic [63:0] BASE64  = 64'(SEL_BASE);
  localparam logic [63:0] SIZE64  = 64'(SEL_SIZE);
  localparam logic [63:0] LIMIT64 = BASE64 + 64'(NSEL) * SIZE64;

  logic [63:0] a64;
  logic [63:0] idx64;

  assign a64   = 64'(addr);
  assign hit   = (a64 >= BASE64) && (a64 < LIMIT64);
  assign idx64 = (a64 - BASE64) / SIZE64;

  for (genvar i = 0; i < NSEL; i++) begin : g_sel
    assign sel[i] = hit && (idx64 == 64'(i));
  end

endmodule

// File: rtl/apb_xfer_ctrl.sv
// APB-side transfer controller: one-entry request buffer, SETUP/ACCESS
// sequencing, slave decode and one response pulse per request.
module apb_xfer_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                NSEL     = NSEL_DEF,
  parameter logic [ADDR_W-1:0] SEL_BASE = ADDR_W'(SEL_BASE_DEF),
  parameter logic [ADDR_W-1:0] SEL_SIZE = ADDR_W'(SEL_SIZE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [NSEL-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  apb_state_e        state_q, state_d;
  req_t              pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [NSEL-1:0]   pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              dec_hit;
  logic [NSEL-1:0]   dec_sel;
  logic              go_xfer;

  // Decode always looks at the buffered request, never the live input.
  apb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NSEL     (NSEL),
    .SEL_BASE (SEL_BASE),
    .SEL_SIZE (SEL_SIZE)
  ) u_dec (
    .addr (pend_q.addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign go_xfer   = pend_full_q && dec_hit;
  assign req_ready = !pend_full_q;

  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next state: misses never leave IDLE, hits chain ACCESS->SETUP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go_xfer) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = go_xfer ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs, response pulse and pending-buffer updates.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    pselx_d     = pselx_q;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          pend_full_d = 1'b0;
          if (dec_hit) begin
            pselx_d  = dec_sel;
            paddr_d  = pend_q.addr;
            pwrite_d = pend_q.write;
            pwdata_d = pend_q.wdata;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = pwrite_q ? '0 : Prdata;
        if (go_xfer) begin
          pend_full_d = 1'b0;
          pselx_d     = dec_sel;
          paddr_d     = pend_q.addr;
          pwrite_d    = pend_q.write;
          pwdata_d    = pend_q.wdata;
        end else begin
          pselx_d = '0;
        end
      end
      default: ;
    endcase

    // Accept only into an empty buffer, so it never collides with a drain.
    if (req_valid && !pend_full_q) begin
      pend_d      = '{write: req_write, addr: req_addr, wdata: req_wdata};
      pend_full_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Bench for apb_xfer_ctrl: directed vectors, hand sequences and a
// randomized run against a transaction-timing reference model.
module tb_apb_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  Pselx;
  logic        Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] Prdata = '0;

  int total = 0;
  int bad   = 0;

  apb_xfer_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic [3:0]  exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // Single isolated request from idle; accept edge N, checks at N+1..N+4.
  task automatic run_vec(input vec_t v);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; Prdata = v.prdata;
    tick();                                   // N: accepted
    req_valid = 1'b0;
    chk("vec_ready_low", 64'(req_ready), 64'(1'b0));
    tick();                                   // N+1
    if (v.exp_err) begin
      chk("vec_miss_rsp", 64'({rsp_valid, rsp_err}), 64'(2'b11));
      chk("vec_miss_rdata", 64'(rsp_rdata), 64'(0));
      chk("vec_miss_sel", 64'({Pselx, Penable}), 64'(0));
    end else begin
      chk("vec_setup_sel", 64'({Pselx, Penable}), 64'({v.exp_sel, 1'b0}));
      chk("vec_setup_addr", 64'({Pwrite, Paddr}), 64'({v.write, v.addr}));
    end
    tick();                                   // N+2
    if (v.exp_err) begin
      chk("vec_miss_once", 64'({rsp_valid, Pselx, Penable}), 64'(0));
    end else begin
      chk("vec_access", 64'({Pselx, Penable, rsp_valid}), 64'({v.exp_sel, 2'b10}));
      chk("vec_access_wdata", 64'(Pwdata), 64'(v.wdata));
    end
    tick();                                   // N+3
    if (!v.exp_err) begin
      chk("vec_rsp", 64'({rsp_valid, rsp_err}), 64'(2'b10));
      chk("vec_rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
      chk("vec_rsp_idle", 64'({Pselx, Penable}), 64'(0));
    end
    tick();                                   // N+4
    chk("vec_rsp_single", 64'(rsp_valid), 64'(1'b0));
  endtask

  // ---------------- reference model ----------------
  localparam int NE = 1024;
  logic [3:0]  exp_sel  [NE];
  logic        exp_en   [NE];
  logic        exp_rv   [NE];
  logic        exp_err  [NE];
  logic [31:0] exp_rd   [NE];
  logic [31:0] exp_addr [NE];
  logic        exp_wr   [NE];
  logic [31:0] exp_wd   [NE];
  logic        rd_due   [NE];
  logic        rd_read  [NE];

  logic        pv;
  logic        pw;
  logic [31:0] pa, pd;
  int          hit_ok, miss_ok;
  logic        acc;
  int          n_rsp_exp, n_rsp_got;

  function automatic logic m_hit(input logic [31:0] a);
    return (64'(a) >= 64'h8000_0000) && (64'(a) < 64'h8000_0000 + 64'd4 * 64'h0400_0000);
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a);
    int idx;
    if (!m_hit(a)) return 4'b0000;
    idx = int'((a - 32'h8000_0000) / 32'h0400_0000);
    return 4'(1 << idx);
  endfunction

  // Timing rules: a hit started at edge S owns the bus for S, S+1 and
  // answers at S+2 (next hit may start at S+2, a miss only at S+3);
  // a miss answers at its own edge M and frees everything from M+1.
  task automatic model_edge(input int e);
    logic rdy;
    rdy = !pv;
    if (rd_due[e]) exp_rd[e] = rd_read[e] ? Prdata : 32'h0;
    if (pv) begin
      if (m_hit(pa) && e >= hit_ok) begin
        for (int k = 0; k < 2; k++) begin
          exp_sel[e+k] = m_sel(pa); exp_en[e+k] = (k == 1);
          exp_addr[e+k] = pa; exp_wr[e+k] = pw; exp_wd[e+k] = pd;
        end
        exp_rv[e+2] = 1'b1; rd_due[e+2] = 1'b1; rd_read[e+2] = !pw;
        hit_ok = e + 2; miss_ok = e + 3; pv = 1'b0; n_rsp_exp++;
      end else if (!m_hit(pa) && e >= miss_ok) begin
        exp_rv[e] = 1'b1; exp_err[e] = 1'b1; exp_rd[e] = 32'h0;
        if (hit_ok < e + 1) hit_ok = e + 1;
        miss_ok = e + 1; pv = 1'b0; n_rsp_exp++;
      end
    end
    acc = req_valid && rdy;
    if (acc) begin
      pv = 1'b1; pw = req_write; pa = req_addr; pd = req_wdata;
    end
  endtask

  task automatic check_edge(input int e);
    chk("rnd_sel", 64'(Pselx), 64'(exp_sel[e]));
    chk("rnd_en", 64'(Penable), 64'(exp_en[e]));
    chk("rnd_rv", 64'(rsp_valid), 64'(exp_rv[e]));
    chk("rnd_ready", 64'(req_ready), 64'(!pv));
    if (exp_rv[e]) begin
      chk("rnd_err", 64'(rsp_err), 64'(exp_err[e]));
      chk("rnd_rdata", 64'(rsp_rdata), 64'(exp_rd[e]));
    end
    if (exp_sel[e] != 4'b0)
      chk("rnd_bus", 64'({Pwrite, Paddr}), 64'({exp_wr[e], exp_addr[e]}));
    if (exp_sel[e] != 4'b0)
      chk("rnd_wdata", 64'(Pwdata), 64'(exp_wd[e]));
    if (rsp_valid) n_rsp_got++;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32'($urandom_range(0, 32'h7FFF_FFFF)) & 32'hFFFF_FFFC;
    if (r == 1) return (32'h9000_0000 + 32'($urandom_range(0, 32'h6FFF_FFFF))) & 32'hFFFF_FFFC;
    return 32'h8000_0000 + (32'($urandom_range(0, 3)) << 26)
           + (32'($urandom_range(0, 32'h03FF_FFFF)) & 32'hFFFF_FFFC);
  endfunction

  initial begin
    vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h5555_5555, 4'b0001, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h8C00_0004, 32'h0000_0042, 32'h1234_5678, 4'b1000, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h7FFF_FFFC, 32'h1111_1111, 32'h9999_9999, 4'b0000, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h9000_0000, 32'h2222_2222, 32'h9999_9999, 4'b0000, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h83FF_FFFC, 32'h0,         32'hA5A5_A5A5, 4'b0001, 1'b0, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 32'h8FFF_FFFC, 32'hCAFE_0001, 32'h7777_7777, 4'b1000, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h8400_0000, 32'h0,         32'h0BAD_F00D, 4'b0010, 1'b0, 32'h0BAD_F00D};

    // Reset state.
    rst = 1'b1;
    tick(); tick();
    chk("rst_bus", 64'({Pselx, Penable, Pwrite, Paddr}), 64'(0));
    chk("rst_wdata", 64'(Pwdata), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1'b1));
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: write slave 1 then read slave 2 with req_valid held.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8400_0000; req_wdata = 32'h0102_0304;
    Prdata = 32'hCAFE_F00D;
    tick();                                   // A: write accepted
    req_write = 1'b0; req_addr = 32'h8800_0000; req_wdata = 32'h0;
    tick();                                   // A+1: SETUP write
    chk("b2b_setup1", 64'({Pselx, Penable}), 64'({4'b0010, 1'b0}));
    chk("b2b_ready1", 64'(req_ready), 64'(1'b1));
    tick();                                   // A+2: ACCESS write, read accepted
    chk("b2b_access1", 64'({Pselx, Penable}), 64'({4'b0010, 1'b1}));
    chk("b2b_full", 64'(req_ready), 64'(1'b0));
    req_valid = 1'b0;
    tick();                                   // A+3: SETUP read, rsp 1
    chk("b2b_rsp1", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b10, 32'h0}));
    chk("b2b_setup2", 64'({Pselx, Penable, Pwrite}), 64'({4'b0100, 2'b00}));
    tick();                                   // A+4: ACCESS read
    chk("b2b_access2", 64'({Pselx, Penable, rsp_valid}), 64'({4'b0100, 2'b10}));
    tick();                                   // A+5: rsp 2
    chk("b2b_rsp2", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b10, 32'hCAFE_F00D}));
    chk("b2b_idle", 64'({Pselx, Penable}), 64'(0));
    tick();

    // Reset during ACCESS of a read: transfer aborted, no response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8800_0008; Prdata = 32'h3333_3333;
    tick();                                   // N: accepted
    req_valid = 1'b0;
    tick();                                   // N+1: SETUP
    tick();                                   // N+2: ACCESS
    chk("rstx_access", 64'({Pselx, Penable}), 64'({4'b0100, 1'b1}));
    rst = 1'b1;
    tick();                                   // reset edge
    chk("rstx_bus", 64'({Pselx, Penable, Pwrite, Paddr}), 64'(0));
    chk("rstx_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    rst = 1'b0;
    tick();
    chk("rstx_norsp", 64'(rsp_valid), 64'(1'b0));
    run_vec(vecs[1]);

    // Randomized run against the model, backpressure included.
    rst = 1'b1; req_valid = 1'b0;
    tick();                                   // edge 0
    rst = 1'b0;
    for (int i = 0; i < NE; i++) begin
      exp_sel[i] = '0; exp_en[i] = 1'b0; exp_rv[i] = 1'b0; exp_err[i] = 1'b0;
      exp_rd[i] = '0; exp_addr[i] = '0; exp_wr[i] = 1'b0; exp_wd[i] = '0;
      rd_due[i] = 1'b0; rd_read[i] = 1'b0;
    end
    pv = 1'b0; pw = 1'b0; pa = '0; pd = '0; hit_ok = 1; miss_ok = 1; acc = 1'b0;
    n_rsp_exp = 0; n_rsp_got = 0;
    for (int e = 1; e <= 800; e++) begin
      if (!req_valid || acc) begin
        if (e < 790 && $urandom_range(0, 3) != 0) begin
          req_valid = 1'b1; req_write = 1'($urandom_range(0, 1));
          req_addr = rnd_addr(); req_wdata = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
      Prdata = $urandom;
      model_edge(e);
      tick();
      check_edge(e);
    end
    chk("rnd_rsp_count", 64'(n_rsp_got), 64'(n_rsp_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
